// File: rtl/udp_app_tx_noc_out_if.sv
// Application-side transmit bundle: send request, payload stream, NoC flit output
// and the two error pulses of the app TX tile.
interface udp_app_tx_noc_out_if #(
   parameter int NOC_DATA_W = 512
);
   logic                  app_tx_hdr_val;
   logic [31:0]           app_tx_hdr_dst_ip;
   logic [15:0]           app_tx_hdr_dst_port;
   logic [15:0]           app_tx_hdr_len;
   logic                  app_tx_hdr_rdy;
   logic                  app_tx_data_val;
   logic [NOC_DATA_W-1:0] app_tx_data;
   logic                  app_tx_data_last;
   logic                  app_tx_data_rdy;
   logic [NOC_DATA_W-1:0] noc_data_out;
   logic                  noc_val_out;
   logic                  noc_rdy_in;
   logic                  len_err;
   logic                  last_err;

   // Application and router side.
   modport master (
      output app_tx_hdr_val, app_tx_hdr_dst_ip, app_tx_hdr_dst_port, app_tx_hdr_len,
      input  app_tx_hdr_rdy,
      output app_tx_data_val, app_tx_data, app_tx_data_last,
      input  app_tx_data_rdy,
      input  noc_data_out, noc_val_out,
      output noc_rdy_in,
      input  len_err, last_err
   );

   // Tile logic side.
   modport slave (
      input  app_tx_hdr_val, app_tx_hdr_dst_ip, app_tx_hdr_dst_port, app_tx_hdr_len,
      output app_tx_hdr_rdy,
      input  app_tx_data_val, app_tx_data, app_tx_data_last,
      output app_tx_data_rdy,
      output noc_data_out, noc_val_out,
      input  noc_rdy_in,
      output len_err, last_err
   );
endinterface

// File: rtl/udp_app_tx_noc_out.sv
// App TX tile: turns a send request plus payload stream into one NoC message
// (header flit, metadata flit, payload flits) addressed to the UDP TX tile.
module udp_app_tx_noc_out #(
   parameter int          NOC_DATA_W = 512,
   parameter int          XY_W       = 3,
   parameter int          SRC_X      = 3,
   parameter int          SRC_Y      = 0,
   parameter int          DST_X      = 2,
   parameter int          DST_Y      = 1,
   parameter logic [7:0]  MSG_TYPE   = 8'h11,
   parameter logic [31:0] SRC_IP     = 32'hc0000002,
   parameter logic [15:0] SRC_PORT   = 16'd60000
) (
   input  logic                   clk,
   input  logic                   rst,
   udp_app_tx_noc_out_if.slave    bus
);

   localparam int FLIT_BYTES = NOC_DATA_W / 8;
   localparam int BYTE_SH    = $clog2(FLIT_BYTES);
   localparam int MAX_DFLITS = 254;
   localparam int HDR_W      = 4 * XY_W + 16;
   localparam int META_W     = 112;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_META,
      S_DATA
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [31:0]           r_dst_ip;
   logic [15:0]           r_dst_port;
   logic [15:0]           r_len;
   logic [7:0]            r_dflits;
   logic [7:0]            r_cnt;
   logic                  r_len_err;
   logic                  r_last_err;

   logic [16:0]           w_dflits_full;
   logic                  w_len_bad;
   logic                  w_hdr_rdy;
   logic                  w_req_fire;
   logic                  w_data_fire;
   logic                  w_final;
   logic                  w_last_bad;
   logic                  w_noc_val;
   logic [NOC_DATA_W-1:0] w_noc_data;
   logic                  w_data_rdy;

   // Ceiling division of the byte length by the flit size, kept 17 bits wide so
   // the oversize check can use the same value without overflow.
   function automatic logic [16:0] f_ceil_flits(input logic [15:0] len);
      return ({1'b0, len} + 17'(FLIT_BYTES - 1)) >> BYTE_SH;
   endfunction

   function automatic logic [NOC_DATA_W-1:0] f_hdr_flit(input logic [7:0] msg_len);
      logic [HDR_W-1:0] used;
      used = {XY_W'(DST_X), XY_W'(DST_Y), XY_W'(SRC_X), XY_W'(SRC_Y), msg_len, MSG_TYPE};
      return {used, {(NOC_DATA_W - HDR_W){1'b0}}};
   endfunction

   function automatic logic [NOC_DATA_W-1:0] f_meta_flit(input logic [31:0] dst_ip,
                                                          input logic [15:0] dst_port,
                                                          input logic [15:0] len);
      logic [META_W-1:0] used;
      used = {SRC_IP, dst_ip, SRC_PORT, dst_port, len};
      return {used, {(NOC_DATA_W - META_W){1'b0}}};
   endfunction

   assign w_dflits_full = f_ceil_flits(bus.app_tx_hdr_len);
   // More than 254 data flits would overflow the 8-bit msg_len field (1 + D).
   assign w_len_bad     = (w_dflits_full > 17'(MAX_DFLITS));
   assign w_hdr_rdy     = (r_state == S_IDLE) && !rst;
   assign w_req_fire    = w_hdr_rdy && bus.app_tx_hdr_val;
   assign w_data_fire   = (r_state == S_DATA) && bus.app_tx_data_val && bus.noc_rdy_in;
   assign w_final       = (r_cnt == (r_dflits - 8'd1));
   assign w_last_bad    = w_final ? !bus.app_tx_data_last : bus.app_tx_data_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_len_err  <= 1'b0;
         r_last_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_len_err  <= w_req_fire && w_len_bad;
         r_last_err <= w_data_fire && w_last_bad;
         if (r_state == S_META) begin
            r_cnt <= '0;
         end else if (w_data_fire) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   // Request fields are only meaningful once accepted, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_req_fire && !w_len_bad) begin
         r_dst_ip   <= bus.app_tx_hdr_dst_ip;
         r_dst_port <= bus.app_tx_hdr_dst_port;
         r_len      <= bus.app_tx_hdr_len;
         r_dflits   <= w_dflits_full[7:0];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_noc_val   = 1'b0;
      w_noc_data  = '0;
      w_data_rdy  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req_fire && !w_len_bad) begin
               w_state_nxt = S_HDR;
            end
         end
         S_HDR: begin
            w_noc_val  = 1'b1;
            w_noc_data = f_hdr_flit(r_dflits + 8'd1);
            if (bus.noc_rdy_in) begin
               w_state_nxt = S_META;
            end
         end
         S_META: begin
            w_noc_val  = 1'b1;
            w_noc_data = f_meta_flit(r_dst_ip, r_dst_port, r_len);
            if (bus.noc_rdy_in) begin
               w_state_nxt = (r_dflits == 8'd0) ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            // Payload passes straight through; the computed flit count decides the end.
            w_noc_val  = bus.app_tx_data_val;
            w_noc_data = bus.app_tx_data;
            w_data_rdy = bus.noc_rdy_in;
            if (w_data_fire && w_final) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.app_tx_hdr_rdy  = w_hdr_rdy;
   assign bus.app_tx_data_rdy = w_data_rdy;
   assign bus.noc_val_out     = w_noc_val;
   assign bus.noc_data_out    = w_noc_data;
   assign bus.len_err         = r_len_err;
   assign bus.last_err        = r_last_err;

endmodule

// File: tb/tb_udp_app_tx_noc_out.sv
// Directed bench for udp_app_tx_noc_out: table of send requests with hand-computed
// message sizes, plus sequences for oversize requests and reset mid-message.
module tb_udp_app_tx_noc_out;

   localparam int W = 512;

   typedef struct {
      logic [15:0] len;
      logic [31:0] ip;
      logic [15:0] port;
      int          msg_len;   // expected header msg_len = 1 + ceil(len/64)
      int          rdy_mode;  // 0: router always ready, 1: ready toggles 1,0,1,0...
      int          last_mode; // 0: correct last, 1: extra last on first flit, 2: final last missing
      int          exp_lerr;  // expected number of last_err pulses
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_err;
   vec_t vecs[7];

   udp_app_tx_noc_out_if #(.NOC_DATA_W(W)) bus ();

   udp_app_tx_noc_out dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] exp_hdr(input int msg_len);
      logic [7:0] ml;
      ml = 8'(msg_len);
      return {3'd2, 3'd1, 3'd3, 3'd0, ml, 8'h11, 484'd0};
   endfunction

   function automatic logic [W-1:0] exp_meta(input logic [15:0] len, input logic [31:0] ip,
                                             input logic [15:0] port);
      return {32'hc0000002, ip, 16'd60000, port, len, 400'd0};
   endfunction

   function automatic logic [W-1:0] pat(input int k);
      return {16{32'hDEAD0000 + 32'(k)}};
   endfunction

   task automatic send_req(input logic [15:0] len, input logic [31:0] ip, input logic [15:0] port);
      @(negedge clk);
      bus.app_tx_hdr_val      = 1'b1;
      bus.app_tx_hdr_len      = len;
      bus.app_tx_hdr_dst_ip   = ip;
      bus.app_tx_hdr_dst_port = port;
      #1;
      chk("req_rdy", W'(bus.app_tx_hdr_rdy), W'(1));
      @(posedge clk);
      #1;
      bus.app_tx_hdr_val = 1'b0;
   endtask

   task automatic run_msg(input vec_t v);
      int       nflits;
      int       nd;
      int       seen;
      int       cyc;
      int       lerr;
      int       k;
      bit       stall_prev;
      bit       rdy_seen;
      logic [W-1:0] prev;
      nflits     = v.msg_len + 1;
      nd         = v.msg_len - 1;
      seen       = 0;
      cyc        = 0;
      lerr       = 0;
      stall_prev = 1'b0;
      rdy_seen   = 1'b0;
      prev       = '0;
      send_req(v.len, v.ip, v.port);
      while (seen < nflits && cyc < 2000) begin
         @(negedge clk);
         bus.noc_rdy_in = (v.rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
         if (seen >= 2) begin
            k = seen - 2;
            bus.app_tx_data_val  = 1'b1;
            bus.app_tx_data      = pat(k);
            bus.app_tx_data_last = (k == nd - 1);
            if (v.last_mode == 1 && k == 0) bus.app_tx_data_last = 1'b1;
            if (v.last_mode == 2 && k == nd - 1) bus.app_tx_data_last = 1'b0;
         end else begin
            bus.app_tx_data_val  = 1'b0;
            bus.app_tx_data_last = 1'b0;
         end
         #1;
         if (bus.last_err) lerr++;
         if (bus.app_tx_data_rdy) rdy_seen = 1'b1;
         if (cyc == 0) chk("hdr_latency", W'(bus.noc_val_out), W'(1));
         if (stall_prev) begin
            chk("stall_val", W'(bus.noc_val_out), W'(1));
            chk("stall_data", bus.noc_data_out, prev);
         end
         if (bus.noc_val_out && bus.noc_rdy_in) begin
            if (seen == 0) begin
               chk("hdr_flit", bus.noc_data_out, exp_hdr(v.msg_len));
            end else if (seen == 1) begin
               chk("meta_flit", bus.noc_data_out, exp_meta(v.len, v.ip, v.port));
            end else begin
               chk("data_flit", bus.noc_data_out, pat(seen - 2));
               chk("data_rdy", W'(bus.app_tx_data_rdy), W'(1));
            end
            seen++;
         end
         stall_prev = bus.noc_val_out && !bus.noc_rdy_in;
         prev       = bus.noc_data_out;
         cyc++;
      end
      chk("flit_count", W'(seen), W'(nflits));
      @(negedge clk);
      bus.app_tx_data_val  = 1'b0;
      bus.app_tx_data_last = 1'b0;
      bus.noc_rdy_in       = 1'b1;
      #1;
      if (bus.last_err) lerr++;
      chk("idle_rdy", W'(bus.app_tx_hdr_rdy), W'(1));
      chk("idle_val", W'(bus.noc_val_out), W'(0));
      chk("last_err_cnt", W'(lerr), W'(v.exp_lerr));
      if (nd == 0) chk("no_data_rdy", W'(rdy_seen), W'(0));
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      vecs[0] = '{16'd100,   32'h0a000005, 16'd1234,  3,   0, 0, 0};
      vecs[1] = '{16'd0,     32'hc0a80101, 16'd53,    1,   0, 0, 0};
      vecs[2] = '{16'd64,    32'h0a000009, 16'd7,     2,   1, 0, 0};
      vecs[3] = '{16'd16256, 32'h0a0000ff, 16'd65535, 255, 0, 0, 0};
      vecs[4] = '{16'd128,   32'h0a000006, 16'd4000,  3,   0, 1, 1};
      vecs[5] = '{16'd65,    32'h0a000007, 16'd8080,  3,   1, 2, 1};
      vecs[6] = '{16'd1,     32'h01020304, 16'd9,     2,   1, 0, 0};

      rst                     = 1'b1;
      bus.app_tx_hdr_val      = 1'b0;
      bus.app_tx_hdr_dst_ip   = '0;
      bus.app_tx_hdr_dst_port = '0;
      bus.app_tx_hdr_len      = '0;
      bus.app_tx_data_val     = 1'b0;
      bus.app_tx_data         = '0;
      bus.app_tx_data_last    = 1'b0;
      bus.noc_rdy_in          = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_hdr_rdy", W'(bus.app_tx_hdr_rdy), W'(0));
      chk("rst_val", W'(bus.noc_val_out), W'(0));
      chk("rst_data_rdy", W'(bus.app_tx_data_rdy), W'(0));
      chk("rst_len_err", W'(bus.len_err), W'(0));
      chk("rst_last_err", W'(bus.last_err), W'(0));
      chk("rst_data", bus.noc_data_out, '0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("post_rst_rdy", W'(bus.app_tx_hdr_rdy), W'(1));

      for (int i = 0; i < 7; i++) begin
         run_msg(vecs[i]);
      end

      // Oversize request: one len_err pulse, no NoC traffic.
      send_req(16'd16257, 32'h0a000005, 16'd1234);
      @(negedge clk);
      #1;
      chk("len_err_pulse", W'(bus.len_err), W'(1));
      chk("len_err_noval", W'(bus.noc_val_out), W'(0));
      @(negedge clk);
      #1;
      chk("len_err_once", W'(bus.len_err), W'(0));
      chk("len_err_noval2", W'(bus.noc_val_out), W'(0));
      chk("len_err_idle", W'(bus.app_tx_hdr_rdy), W'(1));

      // Reset while the metadata flit is stalled.
      send_req(16'd100, 32'h0a000005, 16'd1234);
      @(negedge clk);
      bus.noc_rdy_in = 1'b1;
      #1;
      chk("rst_seq_hdr", bus.noc_data_out, exp_hdr(3));
      @(negedge clk);
      bus.noc_rdy_in = 1'b0;
      rst            = 1'b1;
      #1;
      chk("rst_seq_meta", bus.noc_data_out, exp_meta(16'd100, 32'h0a000005, 16'd1234));
      chk("rst_seq_rdy0", W'(bus.app_tx_hdr_rdy), W'(0));
      @(negedge clk);
      rst            = 1'b0;
      bus.noc_rdy_in = 1'b1;
      #1;
      chk("rst_seq_noval", W'(bus.noc_val_out), W'(0));
      chk("rst_seq_idle", W'(bus.app_tx_hdr_rdy), W'(1));
      run_msg(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
